elevator_scheduler: RTL and testbench
=====================================

// Module: elevator_scheduler
// PURPOSE
//  Request scheduler and motion sequencer for the elevator car (LOOK algorithm).
//  Latches floor-call pulses from the keypad/pushbutton decode and sequences
//  floor-to-floor travel and door dwell.
//  Publishes floor, direction and door status for the display, LED, tune and LCD
//  blocks. Sits between input decode and the display/audio consumers in top level.
// PARAMETERS
//  FLOORS      8   number of floors served (2..16)
//  FLOOR_W     3   width of floor index, ceil(log2(FLOORS))
//  MOVE_TICKS  4   tick strobes needed to travel one floor (>=1)
//  DOOR_TICKS  16  tick strobes door stays open per stop (>=1)
// PORTS
//  clk        in   1         system clock (scan-rate clock domain)
//  rst_n      in   1         asynchronous active-low reset
//  tick       in   1         one-cycle time-base strobe (from freq divider)
//  req        in   FLOORS    call pulses, bit i = floor i; may be held high
//  pending    out  FLOORS    latched outstanding calls (drives call LEDs)
//  floor      out  FLOOR_W   current car floor
//  dir        out  2         2'd0 down, 2'd1 idle, 2'd2 up (display encoding)
//  moving     out  1         high while in MOVE state
//  door_open  out  1         high while in DOOR state
//  arrive     out  1         one-cycle pulse on the cycle DOOR is entered
// BEHAVIOUR
//  Reset (async): state IDLE, floor 0, dir 1, pending 0, moving/door_open/arrive 0,
//   tick counter 0. Reset mid-travel or mid-dwell abandons all calls.
//  Request latch: pending <= (pending | req) & ~clear each cycle; clear is the
//   one-hot of floor on the cycle DOOR is entered (service wins over new call).
//  above = |pending[FLOORS-1:floor+1]; below = |pending[floor-1:0].
//  IDLE: pending[floor] -> DOOR next cycle (no travel); else above -> MOVE, dir=2;
//   else below -> MOVE, dir=0; else stay, dir=1. Up preferred on tie.
//  MOVE: count ticks; on the MOVE_TICKS-th tick floor +/-1 per dir, counter clears.
//   Reaching floor f with pending[f] (evaluated on the new floor) -> DOOR;
//   otherwise stay in MOVE. Floor never wraps: a move is only started when a call
//   exists beyond the car in that direction, and calls are never dropped en route.
//  DOOR: arrive pulses on entry; count DOOR_TICKS ticks, then: calls ahead in dir
//   -> MOVE same dir; else calls behind -> MOVE, dir reversed; else IDLE, dir=1.
//   If dir was idle (stop served from IDLE), apply the IDLE selection rule.
//  tick while entering a state is not counted; counters restart at every state
//   change. Latency: call for floor f>floor in IDLE -> MOVE one cycle later; floor
//   steps after MOVE_TICKS further ticks.
//  Outputs are registered; moving = (state==MOVE), door_open = (state==DOOR).
// CONFIGURATION
//  DOOR_REOPEN_EN defined: a call for the current floor while in DOOR restarts
//   the dwell counter, re-pulses arrive, and is not latched into pending.
//  DOOR_REOPEN_EN undefined: such a call is latched into pending and served
//   after the car next leaves and returns (no dwell extension).
// TESTING (FLOORS=8, MOVE_TICKS=4, DOOR_TICKS=16, tick every 4 clk)
//  Reset, req[5] pulse -> dir=2, floor steps 1..5 every 4 ticks, arrive at 5,
//   pending=0, door_open 16 ticks, then dir=1 IDLE.
//  Car at 3 IDLE, req[3] -> DOOR next cycle, floor stays 3, arrive once.
//  Car at 2 moving up to 6, req[1] and req[4] mid-travel -> stops at 4 then 6,
//   then reverses dir=0 and stops at 1.
//  Car idle at 4, req[7] and req[0] same cycle -> goes up first (7), then 0.
//  Reset asserted mid-MOVE at floor 3 -> floor 0, dir 1, pending 0 immediately.
//  req[floor] during DOOR: with DOOR_REOPEN_EN dwell restarts (32 ticks total
//   if at tick 16); without, pending bit set and door closes on schedule.

Source files
------------

// File: rtl/elevator_scheduler.sv
// elevator_scheduler: LOOK-algorithm floor-call latch plus car motion and door-dwell sequencer.
// Build macro DOOR_REOPEN_EN: a call for the current floor during dwell restarts the door timer.
module elevator_scheduler #(
  parameter int unsigned FLOORS     = 8,
  parameter int unsigned FLOOR_W    = 3,
  parameter int unsigned MOVE_TICKS = 4,
  parameter int unsigned DOOR_TICKS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [FLOORS-1:0]  req,
  output logic [FLOORS-1:0]  pending,
  output logic [FLOOR_W-1:0] floor,
  output logic [1:0]         dir,
  output logic               moving,
  output logic               door_open,
  output logic               arrive
);
  localparam int unsigned MAX_TICKS = (DOOR_TICKS > MOVE_TICKS) ? DOOR_TICKS : MOVE_TICKS;
  localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST = CNT_W'(DOOR_TICKS - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MOVE = 2'd1;
  localparam logic [1:0] DOOR = 2'd2;

  localparam logic [1:0] DIR_DOWN = 2'd0;
  localparam logic [1:0] DIR_IDLE = 2'd1;
  localparam logic [1:0] DIR_UP   = 2'd2;

  logic [1:0]         state, state_n;
  logic [FLOOR_W-1:0] floor_n;
  logic [1:0]         dir_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [FLOORS-1:0]  pending_n, clear, req_mask;
  logic               arrive_n;
  logic               above, below;

  // Outstanding calls strictly above / below the car
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (pending[i] && (FLOOR_W'(i) > floor)) above = 1'b1;
      if (pending[i] && (FLOOR_W'(i) < floor)) below = 1'b1;
    end
  end

  always_comb begin
    state_n  = state;
    floor_n  = floor;
    dir_n    = dir;
    cnt_n    = cnt;
    clear    = '0;
    req_mask = '0;
    arrive_n = 1'b0;

    case (state)
      IDLE: begin
        if (pending[floor]) begin
          state_n = DOOR;
        end else if (above) begin
          state_n = MOVE;
          dir_n   = DIR_UP;
        end else if (below) begin
          state_n = MOVE;
          dir_n   = DIR_DOWN;
        end else begin
          dir_n   = DIR_IDLE;
        end
      end

      MOVE: begin
        if (tick) begin
          if (cnt == MOVE_LAST) begin
            cnt_n   = '0;
            floor_n = (dir == DIR_UP) ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
            if (pending[floor_n]) state_n = DOOR;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      DOOR: begin
`ifdef DOOR_REOPEN_EN
        if (req[floor]) begin
          cnt_n           = '0;
          arrive_n        = 1'b1;
          req_mask[floor] = 1'b1;
        end else
`endif
        if (tick) begin
          if (cnt == DOOR_LAST) begin
            cnt_n = '0;
            // Keep sweeping down only when already heading down; otherwise up wins
            if (dir == DIR_DOWN && below) begin
              state_n = MOVE;
              dir_n   = DIR_DOWN;
            end else if (above) begin
              state_n = MOVE;
              dir_n   = DIR_UP;
            end else if (below) begin
              state_n = MOVE;
              dir_n   = DIR_DOWN;
            end else begin
              state_n = IDLE;
              dir_n   = DIR_IDLE;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // Door entry serves the arrival floor, overriding a same-cycle call
    if (state_n == DOOR && state != DOOR) begin
      arrive_n       = 1'b1;
      clear[floor_n] = 1'b1;
    end
    if (state_n != state) cnt_n = '0;

    pending_n = (pending | (req & ~req_mask)) & ~clear;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      floor     <= '0;
      dir       <= DIR_IDLE;
      cnt       <= '0;
      pending   <= '0;
      moving    <= 1'b0;
      door_open <= 1'b0;
      arrive    <= 1'b0;
    end else begin
      state     <= state_n;
      floor     <= floor_n;
      dir       <= dir_n;
      cnt       <= cnt_n;
      pending   <= pending_n;
      moving    <= (state_n == MOVE);
      door_open <= (state_n == DOOR);
      arrive    <= arrive_n;
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed table, hand-written corner sequences and
// random calls checked every cycle against a ticks-and-calls model of the car.
`timescale 1ns/1ps
module tb_elevator_scheduler;
  localparam int FLOORS     = 8;
  localparam int MOVE_TICKS = 4;
  localparam int DOOR_TICKS = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [7:0] req;
  logic [7:0] pending;
  logic [2:0] floor;
  logic [1:0] dir;
  logic       moving, door_open, arrive;

  elevator_scheduler #(
    .FLOORS(8), .FLOOR_W(3), .MOVE_TICKS(4), .DOOR_TICKS(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .req(req), .pending(pending),
    .floor(floor), .dir(dir), .moving(moving), .door_open(door_open), .arrive(arrive)
  );

  always #5 clk = ~clk;

  // Model: mode 0 waiting, 1 travelling, 2 door open; ticks counted in current mode
  int       m_floor, m_dir, m_mode, m_ticks;
  bit [7:0] m_pend;
  bit       m_arrive;

  int errors = 0;
  int checks = 0;
  int phase  = 0;
  int arrivals[$];

  typedef struct {
    logic [7:0] req;
    int         cycles;
    logic [2:0] floor;
    logic [1:0] dir;
    logic [7:0] pend;
    logic       moving;
    logic       door;
    logic       arr;
  } vec_t;
  vec_t tbl[7];

  task automatic model_reset();
    m_floor = 0; m_dir = 1; m_mode = 0; m_ticks = 0; m_pend = '0; m_arrive = 0;
  endtask

  // Direction to head for: 2 up, 0 down, 1 nothing to do
  function automatic int pick(input int pref);
    int up = 0, dn = 0;
    for (int f = 0; f < FLOORS; f++) begin
      if (m_pend[f] && f > m_floor) up++;
      if (m_pend[f] && f < m_floor) dn++;
    end
    if (pref == 0) return (dn > 0) ? 0 : ((up > 0) ? 2 : 1);
    return (up > 0) ? 2 : ((dn > 0) ? 0 : 1);
  endfunction

  task automatic model_step(input bit [7:0] r, input bit t);
    bit [7:0] np;
    int d;
    np = m_pend | r;
    m_arrive = 0;
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) begin
          m_mode = 2; m_ticks = 0; m_arrive = 1; np[m_floor] = 0;
        end else begin
          d = pick(1);
          m_dir = d;
          if (d != 1) begin m_mode = 1; m_ticks = 0; end
        end
      end
      1: if (t) begin
        m_ticks++;
        if (m_ticks == MOVE_TICKS) begin
          m_ticks = 0;
          m_floor += (m_dir == 2) ? 1 : -1;
          if (m_pend[m_floor]) begin
            m_mode = 2; m_arrive = 1; np[m_floor] = 0;
          end
        end
      end
      default: begin
`ifdef DOOR_REOPEN_EN
        if (r[m_floor]) begin
          m_ticks = 0; m_arrive = 1; np[m_floor] = m_pend[m_floor];
        end else
`endif
        if (t) begin
          m_ticks++;
          if (m_ticks == DOOR_TICKS) begin
            d = pick((m_dir == 0) ? 0 : 1);
            m_ticks = 0;
            m_dir = d;
            m_mode = (d == 1) ? 0 : 1;
          end
        end
      end
    endcase
    m_pend = np;
  endtask

  function automatic logic [15:0] mexp();
    return {3'(m_floor), 2'(m_dir), m_pend, m_mode == 1, m_mode == 2, m_arrive};
  endfunction

  function automatic logic [15:0] dvec();
    return {floor, dir, pending, moving, door_open, arrive};
  endfunction

  function automatic logic [31:0] seq3();
    logic [7:0] a[3];
    for (int i = 0; i < 3; i++) a[i] = (i < arrivals.size()) ? 8'(arrivals[i]) : 8'hFF;
    return {8'(arrivals.size()), a[0], a[1], a[2]};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic run(input logic [7:0] r, input logic t);
    @(negedge clk);
    req = r; tick = t;
    @(posedge clk);
    model_step(r, t);
    #1;
    check("cycle", 32'(dvec()), 32'(mexp()));
    if (arrive) arrivals.push_back(int'(floor));
    phase++;
  endtask

  task automatic prun(input logic [7:0] r);
    run(r, (phase % 4) == 3);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (!(m_mode == 0 && m_pend == 0) && n < max) begin prun(8'h00); n++; end
    check("idle_timeout", 32'(n < max), 32'd1);
  endtask

  task automatic wait_model(input int fl, input int mode, input int max);
    int n = 0;
    while (!(m_floor == fl && m_mode == mode) && n < max) begin prun(8'h00); n++; end
    check("reach_timeout", 32'(n < max), 32'd1);
  endtask

  initial begin
    int dt, guard;
    bit sent;
    logic t;
    logic [7:0] r;

    tbl[0] = '{8'h20,  1, 3'd0, 2'd1, 8'h20, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h00,  1, 3'd0, 2'd2, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h00, 16, 3'd1, 2'd2, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h00, 48, 3'd4, 2'd2, 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h00, 16, 3'd5, 2'd2, 8'h00, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{8'h00, 60, 3'd5, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h00,  4, 3'd5, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; req = '0; tick = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset", 32'(dvec()), 32'({3'd0, 2'd1, 8'h00, 3'b000}));
    @(negedge clk) rst_n = 1'b1;

    // Single call to floor 5 from reset, checkpoints after fixed cycle counts
    for (int i = 0; i < 7; i++) begin
      phase = 0;
      for (int c = 0; c < tbl[i].cycles; c++) prun((c == 0) ? tbl[i].req : 8'h00);
      check($sformatf("tbl%0d", i), 32'(dvec()),
            32'({tbl[i].floor, tbl[i].dir, tbl[i].pend, tbl[i].moving, tbl[i].door, tbl[i].arr}));
    end

    prun(8'h08);
    wait_idle(2000);
    check("at_floor3", 32'(floor), 32'd3);

    // Call for the floor the idle car is on: door next cycle, no travel
    arrivals.delete();
    prun(8'h08);
    prun(8'h00);
    check("door_at_3", 32'({floor, door_open, arrive}), 32'({3'd3, 1'b1, 1'b1}));
    wait_idle(2000);
    check("arrive_once", 32'(arrivals.size()), 32'd1);

    // Calls picked up mid-travel: stops 4, 6, then reverse to 1
    prun(8'h04);
    wait_idle(2000);
    arrivals.delete();
    prun(8'h40);
    wait_model(3, 1, 2000);
    prun(8'h12);
    wait_idle(4000);
    check("stops_4_6_1", seq3(), {8'd3, 8'd4, 8'd6, 8'd1});

    // Simultaneous calls above and below: up first
    prun(8'h10);
    wait_idle(2000);
    arrivals.delete();
    prun(8'h81);
    wait_idle(4000);
    check("stops_7_0", seq3(), {8'd2, 8'd7, 8'd0, 8'hFF});

    // Same-floor call during dwell, issued right after the 15th dwell tick
    prun(8'h04);
    wait_model(2, 2, 2000);
    dt = 0; sent = 0; guard = 0;
    while (door_open && guard < 1000) begin
      t = (phase % 4) == 3;
      r = (dt == 15 && !sent) ? 8'h04 : 8'h00;
      if (r != 0) sent = 1;
      run(r, t);
      if (t) dt++;
      guard++;
    end
`ifdef DOOR_REOPEN_EN
    check("dwell_ticks", 32'(dt), 32'd31);
    check("reopen_pend", 32'(pending[2]), 32'd0);
`else
    check("dwell_ticks", 32'(dt), 32'd16);
    check("latched_pend", 32'(pending[2]), 32'd1);
`endif
    wait_idle(2000);

    // Asynchronous reset while travelling past floor 3
    prun(8'h80);
    wait_model(3, 1, 2000);
    @(negedge clk);
    req = '0; tick = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(dvec()), 32'({3'd0, 2'd1, 8'h00, 3'b000}));
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // Random sparse calls with irregular tick strobes
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 19) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      run(r, $urandom_range(0, 2) == 0);
    end
    wait_idle(20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
